// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter slice.
package i2s_pkg;

  localparam int DATA_WIDTH_DEF = 24;
  localparam int SLOT_WIDTH_DEF = 32;
  localparam int BCLK_DIV_DEF   = 4;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] left;
    logic [DATA_WIDTH_DEF-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_tx_if.sv
// Stereo sample stream into the I2S transmitter (valid/ready handshake).
interface i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic [DATA_WIDTH-1:0] sample_left;
  logic [DATA_WIDTH-1:0] sample_right;
  logic                  sample_valid;
  logic                  sample_ready;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    input  sample_ready
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    output sample_ready
  );

endinterface

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider and frame position counter; produces bclk, lrclk and
// the fall-event / frame-start strobes that pace the shift register.
module i2s_bclk_gen
  import i2s_pkg::*;
#(
  parameter int SLOT_WIDTH = SLOT_WIDTH_DEF,
  parameter int BCLK_DIV   = BCLK_DIV_DEF,
  localparam int BIT_W     = $clog2(2 * SLOT_WIDTH),
  localparam int DIV_W     = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1
) (
  input  logic             clkIn,
  input  logic             reset,
  output logic             bclk,
  output logic             lrclk,
  output logic             fallEvt,
  output logic             frameStart,
  output logic [BIT_W-1:0] nextBit
);

  logic [DIV_W-1:0] divCnt;
  logic [DIV_W-1:0] divCntNext;
  logic [BIT_W-1:0] bitCnt;
  slot_t            slotNext;

  always_comb begin
    fallEvt    = (divCnt == DIV_W'(BCLK_DIV - 1));
    frameStart = fallEvt && (bitCnt == BIT_W'(2 * SLOT_WIDTH - 1));
    divCntNext = fallEvt ? '0 : divCnt + DIV_W'(1);
    nextBit    = frameStart ? '0 : bitCnt + BIT_W'(1);
    // Word select leads the slot by one bit, so it flips at the last bit of the previous slot.
    slotNext   = ((nextBit >= BIT_W'(SLOT_WIDTH - 1)) && (nextBit <= BIT_W'(2 * SLOT_WIDTH - 2)))
                 ? SLOT_RIGHT : SLOT_LEFT;
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      divCnt <= '0;
      bitCnt <= '0;
      bclk   <= 1'b0;
      lrclk  <= 1'b0;
    end else begin
      divCnt <= divCntNext;
      bclk   <= (divCntNext >= DIV_W'(BCLK_DIV / 2));
      if (fallEvt) begin
        bitCnt <= nextBit;
        lrclk  <= (slotNext == SLOT_RIGHT);
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-deep holding register behind a valid/ready handshake,
// a frame-aligned shift register feeding sdata, and underrun signalling.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SLOT_WIDTH = SLOT_WIDTH_DEF,
  parameter int BCLK_DIV   = BCLK_DIV_DEF
) (
  input  logic     clkIn,
  input  logic     reset,
  i2s_tx_if.slave  samples,
  output logic     bclk,
  output logic     lrclk,
  output logic     sdata,
  output logic     underrun
);

  localparam int BIT_W = $clog2(2 * SLOT_WIDTH);

  logic                    fallEvt;
  logic                    frameStart;
  logic [BIT_W-1:0]        nextBit;
  logic                    accept;
  logic                    full;
  logic                    fullNext;
  logic                    dataBit;
  logic [DATA_WIDTH-1:0]   holdLeft;
  logic [DATA_WIDTH-1:0]   holdRight;
  logic [2*DATA_WIDTH-1:0] shiftReg;

  i2s_bclk_gen #(
    .SLOT_WIDTH(SLOT_WIDTH),
    .BCLK_DIV  (BCLK_DIV)
  ) u_bclk_gen (
    .clkIn     (clkIn),
    .reset     (reset),
    .bclk      (bclk),
    .lrclk     (lrclk),
    .fallEvt   (fallEvt),
    .frameStart(frameStart),
    .nextBit   (nextBit)
  );

  always_comb begin
    accept   = samples.sample_valid && samples.sample_ready;
    // Load at frame start empties the register; a same-cycle accept refills it for the next frame.
    fullNext = full;
    if (frameStart) fullNext = 1'b0;
    if (accept)     fullNext = 1'b1;
    dataBit  = ((nextBit >= BIT_W'(1)) && (nextBit <= BIT_W'(DATA_WIDTH))) ||
               ((nextBit >= BIT_W'(SLOT_WIDTH + 1)) && (nextBit <= BIT_W'(SLOT_WIDTH + DATA_WIDTH)));
  end

  always_ff @(posedge clkIn or posedge reset) begin
    if (reset) begin
      full                 <= 1'b0;
      samples.sample_ready <= 1'b1;
      holdLeft             <= '0;
      holdRight            <= '0;
      shiftReg             <= '0;
      sdata                <= 1'b0;
      underrun             <= 1'b0;
    end else begin
      full                 <= fullNext;
      samples.sample_ready <= !fullNext;
      underrun             <= frameStart && !full;
      if (accept) begin
        holdLeft  <= samples.sample_left;
        holdRight <= samples.sample_right;
      end
      if (frameStart) begin
        shiftReg <= full ? {holdLeft, holdRight} : '0;
      end else if (fallEvt && dataBit) begin
        shiftReg <= {shiftReg[2*DATA_WIDTH-2:0], 1'b0};
      end
      if (fallEvt) begin
        sdata <= dataBit && shiftReg[2*DATA_WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: cycle-level model of bclk/lrclk/ready/underrun
// plus a frame scoreboard comparing the serial stream sampled on bclk rises.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int DW    = DATA_WIDTH_DEF;
  localparam int SW    = SLOT_WIDTH_DEF;
  localparam int DIV   = BCLK_DIV_DEF;
  localparam int FRAME = 2 * SW * DIV;
  localparam logic [63:0] LR_PAT = {31'b0, 32'hFFFF_FFFF, 1'b0};
  localparam int NV = 8;

  typedef struct {
    stereo_sample_t s;
    logic [63:0]    expFrame;
  } vec_t;

  logic clkIn = 1'b0;
  logic reset = 1'b1;
  logic bclk, lrclk, sdata, underrun;

  i2s_tx_if #(.DATA_WIDTH(DW)) sIf ();

  i2s_tx #(
    .DATA_WIDTH(DW),
    .SLOT_WIDTH(SW),
    .BCLK_DIV  (DIV)
  ) dut (
    .clkIn   (clkIn),
    .reset   (reset),
    .samples (sIf),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .sdata   (sdata),
    .underrun(underrun)
  );

  always #5 clkIn = ~clkIn;

  int cyc;
  int nChecks = 0;
  int nErrors = 0;
  int frameNo = 0;
  logic [63:0] stimQ[$];
  logic [63:0] pendQ[$];
  logic [63:0] frameQ[$];
  logic expReady = 1'b1;
  logic expUnder = 1'b0;
  logic [63:0] obsFrame, obsLr;
  vec_t vecs[NV];

  always @(posedge clkIn or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic logic [63:0] mkFrame(input stereo_sample_t s);
    return {1'b0, s.left, 7'b0, 1'b0, s.right, 7'b0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s at cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Model and scoreboard, evaluated mid-cycle; the update predicts the next rising edge.
  always @(negedge clkIn) begin
    int pos;
    int bitPos;
    logic [63:0] e;
    if (reset) begin
      pendQ.delete();
      frameQ.delete();
      frameQ.push_back(64'd0);
      expReady = 1'b1;
      expUnder = 1'b0;
      obsFrame = '0;
      obsLr    = '0;
      frameNo  = 0;
    end else begin
      pos    = cyc % FRAME;
      bitPos = pos / DIV;
      chk("bclk", bclk, (cyc % DIV) >= DIV / 2);
      chk("lrclk", lrclk, (bitPos >= SW - 1) && (bitPos <= 2 * SW - 2));
      chk("sample_ready", sIf.sample_ready, expReady);
      chk("underrun", underrun, expUnder);
      if ((cyc % DIV) == DIV / 2) begin
        obsFrame = {obsFrame[62:0], sdata};
        obsLr    = {obsLr[62:0], lrclk};
        if (bitPos == 2 * SW - 1) begin
          chk("frame_expected", frameQ.size() > 0, 1'b1);
          if (frameQ.size() > 0) begin
            e = frameQ.pop_front();
            chk("frame_sdata", obsFrame, e);
            chk("frame_lrclk", obsLr, LR_PAT);
            $display("frame %0d done cyc %0d: sdata=%h want=%h", frameNo, cyc, obsFrame, e);
          end
          frameNo++;
        end
      end
      expUnder = 1'b0;
      if (((cyc + 1) % FRAME) == 0) begin
        if (pendQ.size() > 0) begin
          frameQ.push_back(pendQ.pop_front());
        end else begin
          frameQ.push_back(64'd0);
          expUnder = 1'b1;
        end
      end
      if (sIf.sample_valid && expReady) begin
        chk("stim_available", stimQ.size() > 0, 1'b1);
        if (stimQ.size() > 0) pendQ.push_back(stimQ.pop_front());
        $display("accept at edge %0d: left=%h right=%h", cyc + 1, sIf.sample_left, sIf.sample_right);
      end
      expReady = (pendQ.size() == 0);
    end
  end

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic gotoCyc(input int t);
    int g = 0;
    while (cyc < t && g < 100000) begin
      step();
      g++;
    end
    chk("reach_cyc", cyc, t);
  endtask

  task automatic gotoPos(input int p);
    int g = 0;
    do begin
      step();
      g++;
    end while ((cyc % FRAME) != p && g < 2 * FRAME);
    chk("reach_pos", cyc % FRAME, p);
  endtask

  task automatic sendPair(input logic [DW-1:0] l, input logic [DW-1:0] r);
    stereo_sample_t s;
    logic got;
    s.left  = l;
    s.right = r;
    sIf.sample_left  = l;
    sIf.sample_right = r;
    sIf.sample_valid = 1'b1;
    stimQ.push_back(mkFrame(s));
    got = 1'b0;
    for (int g = 0; g < 600 && !got; g++) begin
      @(negedge clkIn);
      got = sIf.sample_ready;
    end
    chk("accept", got, 1'b1);
    step();
    sIf.sample_valid = 1'b0;
  endtask

  task automatic chkResetOutputs(input string tag);
    chk({tag, "_bclk"}, bclk, 1'b0);
    chk({tag, "_lrclk"}, lrclk, 1'b0);
    chk({tag, "_sdata"}, sdata, 1'b0);
    chk({tag, "_ready"}, sIf.sample_ready, 1'b1);
    chk({tag, "_underrun"}, underrun, 1'b0);
  endtask

  initial begin
    logic got;
    int lastAccept;
    stereo_sample_t c;

    vecs[0].s = '{left: 24'h000001, right: 24'h800000};
    vecs[1].s = '{left: 24'h7FFFFF, right: 24'hFFFFFF};
    vecs[2].s = '{left: 24'h800001, right: 24'h000000};
    vecs[3].s = '{left: 24'hC0FFEE, right: 24'h13579B};
    for (int i = 4; i < NV; i++) begin
      vecs[i].s.left  = 24'h111111 * (i - 3);
      vecs[i].s.right = 24'h111111 * (i - 3) + 24'h1;
    end
    for (int i = 0; i < NV; i++) vecs[i].expFrame = mkFrame(vecs[i].s);

    sIf.sample_valid = 1'b0;
    sIf.sample_left  = '0;
    sIf.sample_right = '0;

    // Reset held for 10 cycles, then released just after an edge.
    repeat (10) @(posedge clkIn);
    #1;
    chkResetOutputs("reset");
    reset = 1'b0;

    // Single pair: accepted in frame 0, played in frame 1.
    sendPair(24'hA5A5A5, 24'h5A5A5A);

    // Underrun: nothing offered before the frame-2 boundary.
    gotoCyc(2 * FRAME);
    chk("underrun_pulse", underrun, 1'b1);
    step();
    chk("underrun_single", underrun, 1'b0);

    // Collision: handshake on the frame-start edge with an empty holding register.
    gotoCyc(3 * FRAME - 1);
    c.left  = 24'h123456;
    c.right = 24'hFEDCBA;
    sIf.sample_left  = c.left;
    sIf.sample_right = c.right;
    sIf.sample_valid = 1'b1;
    stimQ.push_back(mkFrame(c));
    step();
    sIf.sample_valid = 1'b0;
    chk("collision_underrun", underrun, 1'b1);
    chk("collision_ready", sIf.sample_ready, 1'b0);

    // Back-to-back: valid held high, one pair per frame.
    lastAccept = 0;
    sIf.sample_valid = 1'b1;
    for (int i = 0; i < NV; i++) begin
      sIf.sample_left  = vecs[i].s.left;
      sIf.sample_right = vecs[i].s.right;
      stimQ.push_back(vecs[i].expFrame);
      got = 1'b0;
      for (int g = 0; g < 600 && !got; g++) begin
        @(negedge clkIn);
        got = sIf.sample_ready;
      end
      chk("b2b_accept", got, 1'b1);
      step();
      if (i > 0) chk("b2b_interval", cyc - lastAccept, FRAME);
      lastAccept = cyc;
    end
    sIf.sample_valid = 1'b0;
    gotoCyc(cyc + 3 * FRAME);

    // Mid-frame reset at bit 10 of the left slot with a second pair held.
    sendPair(24'hFFFFFF, 24'h000F0F);
    gotoPos(0);
    sendPair(24'h654321, 24'h0ABCDE);
    gotoPos(10 * DIV + DIV / 2);
    chk("pre_reset_sdata", sdata, 1'b1);
    chk("pre_reset_bclk", bclk, 1'b1);
    chk("pre_reset_ready", sIf.sample_ready, 1'b0);
    reset = 1'b1;
    #1;
    chkResetOutputs("async_reset");
    repeat (3) @(posedge clkIn);
    #1;
    reset = 1'b0;
    gotoCyc(FRAME);
    chk("discarded_pair_underrun", underrun, 1'b1);
    gotoCyc(2 * FRAME + 10);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
